// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the next-PC select encodings, special instruction words and FSM states.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection and target legality check for the fetch stage.
// Purely combinational; the caller decides whether the result is committed.
module pc_next
    import fetch_unit_pkg::*;
#(
    parameter int N        = 32,
    parameter int IM_WORDS = 32
) (
    input  logic [N-1:0] i_pc,
    input  logic [1:0]   i_pcSrc,
    input  logic [N-1:0] i_branchTarget,
    input  logic [N-1:0] i_jalrTarget,
    output logic [N-1:0] o_nextPc,
    output logic         o_fault
);

    // One bit wider than the PC so the byte limit itself is representable.
    localparam logic [N:0] IM_BYTES = (N+1)'(IM_WORDS * 4);

    logic [N-1:0] w_target;
    logic [N-1:0] w_jalrAligned;

    assign w_jalrAligned = i_jalrTarget & ~N'(1);

    always_comb begin
        w_target = i_pc + N'(4);
        case (i_pcSrc)
            PC_SRC_BRANCH: w_target = i_branchTarget;
            PC_SRC_JALR:   w_target = w_jalrAligned;
            default:       w_target = i_pc + N'(4);
        endcase
    end

    assign o_nextPc = w_target;
    assign o_fault  = (w_target[1:0] != 2'b00) || ({1'b0, w_target} >= IM_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// A faulting target or a captured EBREAK stops fetch until the next reset.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           IM_WORDS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   pc_src,
    input  logic [N-1:0] branch_target,
    input  logic [N-1:0] jalr_target,
    input  logic         stall,
    input  logic         flush,
    input  logic [N-1:0] inst_in,
    output logic [4:0]   addressIM,
    output logic [N-1:0] pc,
    output logic [N-1:0] if_pc,
    output logic [N-1:0] if_inst,
    output logic         if_valid,
    output logic         fault,
    output logic         halted
);

    fetch_state_t r_state;
    fetch_state_t w_nextState;

    logic [N-1:0] r_pc;
    logic [N-1:0] r_ifPc;
    logic [N-1:0] r_ifInst;
    logic         r_ifValid;
    logic         r_fault;
    logic         r_halted;

    logic [N-1:0] w_nextPc;
    logic         w_targetFault;
    logic         w_pcAdvance;
    logic         w_ebreakSeen;

    logic         w_pcLoad;
    logic         w_capture;
    logic         w_squash;
    logic         w_clearValid;
    logic         w_setFault;
    logic         w_setHalt;

    pc_next #(
        .N        (N),
        .IM_WORDS (IM_WORDS)
    ) u_pcNext (
        .i_pc           (r_pc),
        .i_pcSrc        (pc_src),
        .i_branchTarget (branch_target),
        .i_jalrTarget   (jalr_target),
        .o_nextPc       (w_nextPc),
        .o_fault        (w_targetFault)
    );

    // Flush must move the PC to the redirect target even while stalled.
    assign w_pcAdvance  = flush || !stall;
    assign w_ebreakSeen = r_ifValid && (r_ifInst == N'(INST_EBREAK));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_BOOT: w_nextState = ST_RUN;
            ST_RUN: begin
                if (w_ebreakSeen || (w_pcAdvance && w_targetFault)) begin
                    w_nextState = ST_HALT;
                end
            end
            ST_HALT: w_nextState = ST_HALT;
            default: w_nextState = ST_BOOT;
        endcase
    end

    always_comb begin
        w_pcLoad     = 1'b0;
        w_capture    = 1'b0;
        w_squash     = 1'b0;
        w_clearValid = 1'b0;
        w_setFault   = 1'b0;
        w_setHalt    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_ebreakSeen) begin
                    w_setHalt    = 1'b1;
                    w_clearValid = 1'b1;
                end else if (w_pcAdvance) begin
                    if (w_targetFault) begin
                        w_setFault   = 1'b1;
                        w_setHalt    = 1'b1;
                        w_clearValid = 1'b1;
                    end else begin
                        w_pcLoad  = 1'b1;
                        w_squash  = flush;
                        w_capture = !flush;
                    end
                end
            end
            ST_HALT: w_clearValid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ifPc    <= '0;
            r_ifInst  <= N'(INST_NOP);
            r_ifValid <= 1'b0;
            r_fault   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            if (w_pcLoad) begin
                r_pc <= w_nextPc;
            end
            if (w_capture) begin
                r_ifInst  <= inst_in;
                r_ifPc    <= r_pc;
                r_ifValid <= 1'b1;
            end else if (w_squash) begin
                r_ifInst  <= N'(INST_NOP);
                r_ifValid <= 1'b0;
            end else if (w_clearValid) begin
                r_ifValid <= 1'b0;
            end
            if (w_setFault) begin
                r_fault <= 1'b1;
            end
            if (w_setHalt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign addressIM = r_pc[6:2];
    assign pc        = r_pc;
    assign if_pc     = r_ifPc;
    assign if_inst   = r_ifInst;
    assign if_valid  = r_ifValid;
    assign fault     = r_fault;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors feed a scoreboard queue
// that a negedge monitor drains whenever the IF/ID register shows a valid word.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        stall;
    logic        flush;
    logic [31:0] inst_in;
    logic [4:0]  addressIM;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        fault;
    logic        halted;

    logic [31:0] imem [32];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    fetch_unit #(
        .N        (32),
        .RESET_PC (32'h0000_0000),
        .IM_WORDS (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .stall         (stall),
        .flush         (flush),
        .inst_in       (inst_in),
        .addressIM     (addressIM),
        .pc            (pc),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid),
        .fault         (fault),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory answers combinationally, as the real one does.
    assign inst_in = imem[addressIM];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Every cycle the DUT shows a valid IF/ID word, one expectation is consumed.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_valid: got pc %h inst %h, expected no valid word",
                         if_pc, if_inst);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_if_pc", if_pc, e.pc);
                checkOutput("sb_if_inst", if_inst, e.inst);
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic fl, input logic [1:0] src,
                                 input logic [31:0] bt, input logic [31:0] jt,
                                 input logic expValid, input logic [31:0] expPc,
                                 input logic [31:0] expInst);
        stall         = st;
        flush         = fl;
        pc_src        = src;
        branch_target = bt;
        jalr_target   = jt;
        if (expValid) begin
            expQ.push_back(exp_t'{pc: expPc, inst: expInst});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetchExpect(input logic [31:0] expPc, input logic [31:0] expInst);
        applyStimulus(1'b0, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0, 1'b1, expPc, expInst);
    endtask

    task automatic quietCycle(input logic st, input logic fl, input logic [1:0] src,
                              input logic [31:0] bt, input logic [31:0] jt);
        applyStimulus(st, fl, src, bt, jt, 1'b0, 32'h0, 32'h0);
    endtask

    // Reset is applied with hostile inputs to show it overrides them.
    task automatic doReset();
        rst_n = 1'b0;
        quietCycle(1'b1, 1'b1, PC_SRC_BRANCH, 32'h0000_0040, 32'h0000_0021);
        rst_n = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"}, pc, 32'h0000_0000);
        checkOutput({tag, "_if_pc"}, if_pc, 32'h0000_0000);
        checkOutput({tag, "_if_inst"}, if_inst, 32'h0000_0013);
        checkOutput({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
        checkOutput({tag, "_fault"}, {31'b0, fault}, 32'h0);
        checkOutput({tag, "_halted"}, {31'b0, halted}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            imem[i] = 32'hA000_0000 + i;
        end
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        pc_src = PC_SRC_SEQ;
        branch_target = 32'h0;
        jalr_target = 32'h0;

        // Reset, BOOT, then four sequential fetches.
        doReset();
        checkResetState("reset");
        checkOutput("reset_addressIM", {27'b0, addressIM}, 32'h0);
        quietCycle(1'b0, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0);
        checkOutput("boot_pc", pc, 32'h0000_0000);
        checkOutput("boot_if_valid", {31'b0, if_valid}, 32'h0);
        fetchExpect(32'h0000_0000, 32'hA000_0000);
        fetchExpect(32'h0000_0004, 32'hA000_0001);
        fetchExpect(32'h0000_0008, 32'hA000_0002);
        fetchExpect(32'h0000_000C, 32'hA000_0003);
        checkOutput("seq_pc", pc, 32'h0000_0010);
        checkOutput("seq_addressIM", {27'b0, addressIM}, 32'h4);

        // Stall three cycles at 0x10; the held word is seen valid each cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0, 1'b1, 32'h0000_000C, 32'hA000_0003);
            checkOutput("stall_pc", pc, 32'h0000_0010);
        end
        quietCycle(1'b1, 1'b1, PC_SRC_SEQ, 32'h0, 32'h0);
        checkOutput("stallflush_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("stallflush_pc", pc, 32'h0000_0014);
        checkOutput("stallflush_inst", if_inst, 32'h0000_0013);
        fetchExpect(32'h0000_0014, 32'hA000_0005);
        fetchExpect(32'h0000_0018, 32'hA000_0006);

        // Branch back to 8, then branch from 8 to 0x14.
        quietCycle(1'b0, 1'b1, PC_SRC_BRANCH, 32'h0000_0008, 32'h0);
        checkOutput("br1_pc", pc, 32'h0000_0008);
        quietCycle(1'b0, 1'b1, PC_SRC_BRANCH, 32'h0000_0014, 32'h0);
        checkOutput("br2_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("br2_inst", if_inst, 32'h0000_0013);
        fetchExpect(32'h0000_0014, 32'hA000_0005);

        // jalr: odd target is aligned, misaligned target faults and halts.
        quietCycle(1'b0, 1'b1, PC_SRC_JALR, 32'h0, 32'h0000_000D);
        checkOutput("jalr_pc", pc, 32'h0000_000C);
        checkOutput("jalr_nofault", {31'b0, fault}, 32'h0);
        fetchExpect(32'h0000_000C, 32'hA000_0003);
        quietCycle(1'b0, 1'b1, PC_SRC_JALR, 32'h0, 32'h0000_000E);
        checkOutput("jalrbad_fault", {31'b0, fault}, 32'h1);
        checkOutput("jalrbad_halted", {31'b0, halted}, 32'h1);
        checkOutput("jalrbad_pc", pc, 32'h0000_0010);
        for (int i = 0; i < 2; i++) begin
            quietCycle(1'b0, 1'b0, PC_SRC_BRANCH, 32'h0000_0000, 32'h0);
            checkOutput("halt_pc", pc, 32'h0000_0010);
            checkOutput("halt_valid", {31'b0, if_valid}, 32'h0);
        end

        // Reset out of HALT, restart from 0, then sequential fetch off the end.
        doReset();
        checkResetState("rehalt");
        quietCycle(1'b0, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0);
        fetchExpect(32'h0000_0000, 32'hA000_0000);
        quietCycle(1'b0, 1'b1, PC_SRC_BRANCH, 32'h0000_007C, 32'h0);
        checkOutput("edge_pc", pc, 32'h0000_007C);
        checkOutput("edge_nofault", {31'b0, fault}, 32'h0);
        quietCycle(1'b0, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0);
        checkOutput("wrap_fault", {31'b0, fault}, 32'h1);
        checkOutput("wrap_halted", {31'b0, halted}, 32'h1);
        checkOutput("wrap_pc", pc, 32'h0000_007C);
        checkOutput("wrap_valid", {31'b0, if_valid}, 32'h0);

        // EBREAK at word 5 stops fetch one cycle after it is captured.
        imem[5] = INST_EBREAK;
        doReset();
        quietCycle(1'b0, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0);
        fetchExpect(32'h0000_0000, 32'hA000_0000);
        fetchExpect(32'h0000_0004, 32'hA000_0001);
        fetchExpect(32'h0000_0008, 32'hA000_0002);
        fetchExpect(32'h0000_000C, 32'hA000_0003);
        fetchExpect(32'h0000_0010, 32'hA000_0004);
        fetchExpect(32'h0000_0014, INST_EBREAK);
        checkOutput("ebreak_not_yet_halted", {31'b0, halted}, 32'h0);
        quietCycle(1'b0, 1'b0, PC_SRC_SEQ, 32'h0, 32'h0);
        checkOutput("ebreak_halted", {31'b0, halted}, 32'h1);
        checkOutput("ebreak_if_pc", if_pc, 32'h0000_0014);
        checkOutput("ebreak_valid", {31'b0, if_valid}, 32'h0);
        checkOutput("ebreak_nofault", {31'b0, fault}, 32'h0);
        quietCycle(1'b0, 1'b1, PC_SRC_BRANCH, 32'h0000_0000, 32'h0);
        checkOutput("ebreak_hold_pc", pc, 32'h0000_0018);
        checkOutput("ebreak_hold_inst", if_inst, INST_EBREAK);

        checkOutput("scoreboard_drained", expQ.size(), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, default 32, datapath width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter IM_WORDS, default 32, instruction-memory depth in words; the memory index is 5 bits wide.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jalr, 11 treated as 00.
REQ-007 branch_target  in  N  branch/jal target byte address.
REQ-008 jalr_target  in  N  jalr target byte address, before bit-0 clearing.
REQ-009 stall  in  1  hold PC and IF/ID register.
REQ-010 flush  in  1  squash the IF/ID contents.
REQ-011 inst_in  in  N  word from instruction memory, combinational response to addressIM.
REQ-012 addressIM  out  5  word index to instruction memory: pc[6:2].
REQ-013 pc  out  N  current fetch PC.
REQ-014 if_pc, if_inst, if_valid  out  N, N, 1  IF/ID pipeline register.
REQ-015 fault  out  1  sticky; set on misaligned or out-of-range target.
REQ-016 halted  out  1  sticky; set when fetch has stopped.

Function
REQ-017 FSM states: BOOT, RUN, HALT; reset enters BOOT.
REQ-018 BOOT lasts exactly one cycle, then goes unconditionally to RUN; pc=RESET_PC and if_valid=0 during BOOT.
REQ-019 In RUN with stall=0 and flush=0, each cycle: if_inst<=inst_in, if_pc<=pc, if_valid<=1, pc<=next_pc.
REQ-020 next_pc: pc_src 00/11 -> pc+4; 01 -> branch_target; 10 -> {jalr_target[N-1:1],1'b0}; all additions modulo 2^N.
REQ-021 Redirect timing: when pc_src!=00, the caller asserts flush in the same cycle; that word is not captured, and the target word appears in if_inst one cycle later.
REQ-022 flush=1: if_valid<=0 and if_inst<=32'h0000_0013 (NOP); pc<=next_pc; flush overrides stall.
REQ-023 stall=1 with flush=0: pc, if_pc, if_inst and if_valid hold their values.
REQ-024 Fault check on next_pc whenever pc would update: next_pc[1:0]!=0, or next_pc >= IM_WORDS*4 -> fault<=1, halted<=1, go to HALT, pc holds.
REQ-025 Sequential wrap past the last word (pc=IM_WORDS*4-4, pc_src=00) is a fault per REQ-024; pc never wraps silently.
REQ-026 EBREAK: when 32'h0010_0073 is captured into if_inst with if_valid=1, go to HALT next cycle; the EBREAK stays visible with if_valid=1 for one cycle, then if_valid<=0.
REQ-027 HALT is absorbing until reset: pc and if_inst hold, if_valid=0, halted=1, and stall, flush and pc_src are ignored.
REQ-028 addressIM is purely combinational from pc, so inst_in is valid in the same cycle.

Reset
REQ-029 When rst_n=0 at a clock edge: pc<=RESET_PC, if_pc<=0, if_inst<=32'h0000_0013, if_valid<=0, fault<=0, halted<=0, state<=BOOT.
REQ-030 Reset asserted mid-operation, including in HALT, overrides every other input at that edge.
REQ-031 No state changes on an rst_n edge alone; reset acts only at a clk edge.

Structure
REQ-032 A shared package holds: the pc_src encodings, the NOP and EBREAK constants, and the FSM state type.
REQ-033 One sub-module, pc_next, computes next_pc and the fault flag combinationally; the FSM and registers live in fetch_unit.

Verification
REQ-034 Reset then 4 free-running cycles with memory words 0..3 -> if_pc 0,4,8,12 on consecutive cycles after BOOT, if_valid=1.
REQ-035 pc=8, pc_src=01, branch_target=0x14, flush=1 -> next cycle if_valid=0 and if_inst=0x13; following cycle if_pc=0x14.
REQ-036 jalr_target=0x0D -> next fetch at 0x0C, no fault; jalr_target=0x0E -> fault=1, halted=1, pc unchanged.
REQ-037 stall held 3 cycles at pc=0x10 -> pc, if_pc and if_inst constant; stall+flush together -> if_valid=0 and pc advances.
REQ-038 Sequential fetch at pc=0x7C -> fault=1 and HALT; EBREAK at word 5 -> halted=1 with if_pc=0x14.
REQ-039 rst_n=0 while in HALT -> all outputs at reset values next edge; fetch restarts from 0 after BOOT.
